prio_enc_pow2: RTL and testbench
================================

// Module: prio_enc_pow2
// PURPOSE
// - Priority encoder: 2**WIDTH-bit request vector -> WIDTH-bit index of the winning set bit.
// - Used by the associative caches for hit-line selection (one-hot tag matches) and
//   victim selection (first invalid line); both run combinationally, in-cycle.
// - Also provides a registered copy of the result for timing-relaxed consumers.
// PARAMETERS
// - WIDTH      default 3  output index width; input width N = 2**WIDTH (WIDTH >= 1).
// - LOW_FIRST  default 1  1: lowest set index wins; 0: highest set index wins.
// PORTS
// - clk       in   1        clock, rising edge.
// - rst_n     in   1        reset, asynchronous, active-low.
// - in        in   2**WIDTH request vector; bit i = request from index i.
// - result    out  WIDTH    combinational winning index.
// - valid     out  1        combinational; 1 when any bit of in is set.
// - result_r  out  WIDTH    result registered on clk.
// - valid_r   out  1        valid registered on clk.
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - result/valid: purely combinational from in; independent of clk and rst_n, including
//   during reset; zero latency.
// - LOW_FIRST=1: result = smallest i with in[i]=1. LOW_FIRST=0: largest such i.
// - in == 0: result = 0, valid = 0 (consumers gate on valid; result 0 is not a hit).
// - One-hot in: result = position of the single set bit, both priority settings agree.
// - All ones: result = 0 (LOW_FIRST=1) or 2**WIDTH-1 (LOW_FIRST=0).
// - result_r/valid_r: capture result/valid on every rising clk edge; 1-cycle latency;
//   no enable, no handshake.
// - rst_n low: result_r = 0, valid_r = 0 immediately (async); hold until first rising clk
//   after rst_n deasserts. Reset mid-stream discards the pending captured value.
// - No X propagation from unknown high-order bits when a winning lower bit is set
//   (LOW_FIRST=1); implement as a priority loop, not a one-hot OR reduction.
// - Width rules: result is exactly WIDTH bits; index 2**WIDTH-1 is representable;
//   no truncation warnings for WIDTH 1..6.
// - Elaboration: WIDTH < 1 -> $fatal.
// STRUCTURE
// - No shared package; no typedefs required. Single module, no sub-modules.
// - Combinational core: one always_comb loop over N bits honoring LOW_FIRST.
// - Output register: one always_ff with async active-low reset.
// TESTING
// - WIDTH=3, in=8'b0000_0000 -> result=0, valid=0; next clk result_r=0, valid_r=0.
// - WIDTH=3, in=8'b0010_0000 -> result=5, valid=1; after clk result_r=5, valid_r=1.
// - WIDTH=3, LOW_FIRST=1, in=8'b1001_0100 -> result=2; LOW_FIRST=0 same in -> result=7.
// - WIDTH=3, sweep one-hot 1<<i for i=0..7 -> result=i each cycle; result_r lags by one clk.
// - Assert rst_n=0 between clk edges with in=8'hFF -> result_r/valid_r drop to 0 at once,
//   result/valid stay 0/1 (LOW_FIRST=1); release -> next clk result_r=0, valid_r=1.
// - WIDTH=1, in=2'b10 -> result=1; WIDTH=5, in=1<<31 -> result=31, valid=1.

Source files
------------

// File: rtl/prio_enc_pow2.sv
// -----------------------------------------------------------------------------
// prio_enc_pow2
//   Priority encoder that turns a 2**WIDTH-bit request vector into the WIDTH-bit
//   index of the winning set bit. The associative caches use it in-cycle for
//   hit-line selection (one-hot tag matches) and victim selection (first invalid
//   line). A registered copy of the result serves timing-relaxed consumers.
//
//   Parameters
//     WIDTH      index width; request width is 2**WIDTH (WIDTH >= 1)
//     LOW_FIRST  1: lowest set index wins, 0: highest set index wins
//
//   Ports
//     clk       in   1          clock, rising edge
//     rst_n     in   1          asynchronous active-low reset (registered side only)
//     in        in   2**WIDTH   request vector, bit i = request from index i
//     result    out  WIDTH      combinational winning index (0 when nothing set)
//     valid     out  1          combinational, 1 when any request bit is set
//     result_r  out  WIDTH      result captured on every rising clk edge
//     valid_r   out  1          valid captured on every rising clk edge
// -----------------------------------------------------------------------------
module prio_enc_pow2 #(
   parameter int WIDTH     = 3,
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2**WIDTH-1:0]   in,
   output logic [WIDTH-1:0]      result,
   output logic                  valid,
   output logic [WIDTH-1:0]      result_r,
   output logic                  valid_r
);

   localparam int N = 2**WIDTH;

   // A zero-width index cannot address anything, so stop elaboration outright.
   if (WIDTH < 1) begin : g_width_check
      $fatal(1, "prio_enc_pow2: WIDTH must be >= 1 (got %0d)", WIDTH);
   end

   // Priority loop: the scan runs from the losing end toward the winning end so
   // the last set bit visited overwrites earlier ones. Because the winner is the
   // final assignment, an unknown bit on the losing side cannot corrupt the
   // result once a winning bit is set, unlike a one-hot OR reduction.
   always_comb begin
      result = '0;
      valid  = 1'b0;
      if (LOW_FIRST) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
               result = WIDTH'(i);
               valid  = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (in[i]) begin
               result = WIDTH'(i);
               valid  = 1'b1;
            end
         end
      end
   end

   // Output register: free-running capture with no enable. Reset clears it
   // immediately, discarding whatever was captured before reset arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= '0;
         valid_r  <= 1'b0;
      end else begin
         result_r <= result;
         valid_r  <= valid;
      end
   end

endmodule

// File: tb/tb_prio_enc_pow2.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_pow2
//   Self-checking bench for prio_enc_pow2. Four instances share one clock and
//   reset: WIDTH=3 low-first, WIDTH=3 high-first (same request vector),
//   WIDTH=1 and WIDTH=5 low-first. Expected registered outputs are pushed to a
//   scoreboard queue when stimulus is driven and popped after the next edge.
// -----------------------------------------------------------------------------
module tb_prio_enc_pow2;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in3;
   logic [1:0]  in1;
   logic [31:0] in5;

   logic [2:0]  res3l, res3l_r, res3h, res3h_r;
   logic        val3l, val3l_r, val3h, val3h_r;
   logic        res1, res1_r, val1, val1_r;
   logic [4:0]  res5, res5_r;
   logic        val5, val5_r;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int res_lo;
      int val_lo;
      int res_hi;
      int val_hi;
   } exp_t;

   exp_t sb[$];

   prio_enc_pow2 #(.WIDTH(3), .LOW_FIRST(1'b1)) u_w3_lo (
      .clk(clk), .rst_n(rst_n), .in(in3),
      .result(res3l), .valid(val3l), .result_r(res3l_r), .valid_r(val3l_r));

   prio_enc_pow2 #(.WIDTH(3), .LOW_FIRST(1'b0)) u_w3_hi (
      .clk(clk), .rst_n(rst_n), .in(in3),
      .result(res3h), .valid(val3h), .result_r(res3h_r), .valid_r(val3h_r));

   prio_enc_pow2 #(.WIDTH(1), .LOW_FIRST(1'b1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in(in1),
      .result(res1), .valid(val1), .result_r(res1_r), .valid_r(val1_r));

   prio_enc_pow2 #(.WIDTH(5), .LOW_FIRST(1'b1)) u_w5 (
      .clk(clk), .rst_n(rst_n), .in(in5),
      .result(res5), .valid(val5), .result_r(res5_r), .valid_r(val5_r));

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: scan from the winning end and stop at the first set bit.
   function automatic int modelIdx(input logic [63:0] v, input int n, input bit low);
      if (low) begin
         for (int i = 0; i < n; i++) if (v[i]) return i;
      end else begin
         for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic int modelValid(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) if (v[i]) return 1;
      return 0;
   endfunction

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drive one WIDTH=3 vector just after a rising edge, check the combinational
   // outputs, queue the registered expectation, then check it after the edge.
   task automatic applyStimulus(input logic [7:0] v);
      exp_t e;
      exp_t got;
      in3 = v;
      #1;
      e.res_lo = modelIdx({56'd0, v}, 8, 1'b1);
      e.res_hi = modelIdx({56'd0, v}, 8, 1'b0);
      e.val_lo = modelValid({56'd0, v}, 8);
      e.val_hi = e.val_lo;
      checkOutput("w3lo_result", int'(res3l), e.res_lo);
      checkOutput("w3lo_valid",  int'(val3l), e.val_lo);
      checkOutput("w3hi_result", int'(res3h), e.res_hi);
      checkOutput("w3hi_valid",  int'(val3h), e.val_hi);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checkOutput("scoreboard_empty", 0, 1);
      end else begin
         got = sb.pop_front();
         checkOutput("w3lo_result_r", int'(res3l_r), got.res_lo);
         checkOutput("w3lo_valid_r",  int'(val3l_r), got.val_lo);
         checkOutput("w3hi_result_r", int'(res3h_r), got.res_hi);
         checkOutput("w3hi_valid_r",  int'(val3h_r), got.val_hi);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in3   = 8'h00;
      in1   = 2'b00;
      in5   = 32'd0;

      // Reset state, sampled between edges while reset is held.
      #12;
      checkOutput("rst_w3lo_result_r", int'(res3l_r), 0);
      checkOutput("rst_w3lo_valid_r",  int'(val3l_r), 0);
      checkOutput("rst_w3hi_result_r", int'(res3h_r), 0);
      checkOutput("rst_w3_valid",      int'(val3l),   0);
      checkOutput("rst_w1_valid_r",    int'(val1_r),  0);
      checkOutput("rst_w5_valid_r",    int'(val5_r),  0);

      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases: empty, single bit, mixed priority, all ones.
      applyStimulus(8'b0000_0000);
      applyStimulus(8'b0010_0000);
      applyStimulus(8'b1001_0100);
      applyStimulus(8'hFF);

      // One-hot sweep: both priority settings must agree.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'(1 << i));
      end

      // Random vectors.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(8'($urandom_range(0, 255)));
      end

      // Mid-cycle reset with all requests set: registered side clears at once,
      // combinational side keeps encoding.
      in3 = 8'hFF;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("midrst_w3lo_result_r", int'(res3l_r), 0);
      checkOutput("midrst_w3lo_valid_r",  int'(val3l_r), 0);
      checkOutput("midrst_w3hi_result_r", int'(res3h_r), 0);
      checkOutput("midrst_w3hi_valid_r",  int'(val3h_r), 0);
      checkOutput("midrst_w3lo_result",   int'(res3l),   0);
      checkOutput("midrst_w3lo_valid",    int'(val3l),   1);
      checkOutput("midrst_w3hi_result",   int'(res3h),   7);
      #2;
      rst_n = 1'b1;
      #1;
      checkOutput("rel_hold_valid_r", int'(val3l_r), 0);
      @(posedge clk);
      #1;
      checkOutput("rel_w3lo_result_r", int'(res3l_r), 0);
      checkOutput("rel_w3lo_valid_r",  int'(val3l_r), 1);
      checkOutput("rel_w3hi_result_r", int'(res3h_r), 7);
      checkOutput("rel_w3hi_valid_r",  int'(val3h_r), 1);

      // WIDTH=1 boundary cases.
      in1 = 2'b10;
      #1;
      checkOutput("w1_result_10", int'(res1), 1);
      checkOutput("w1_valid_10",  int'(val1), 1);
      @(posedge clk);
      #1;
      checkOutput("w1_result_r_10", int'(res1_r), 1);
      in1 = 2'b11;
      #1;
      checkOutput("w1_result_11", int'(res1), 0);
      in1 = 2'b00;
      #1;
      checkOutput("w1_valid_00", int'(val1), 0);

      // WIDTH=5 top index and random vectors.
      in5 = 32'h8000_0000;
      #1;
      checkOutput("w5_result_top", int'(res5), 31);
      checkOutput("w5_valid_top",  int'(val5), 1);
      @(posedge clk);
      #1;
      checkOutput("w5_result_r_top", int'(res5_r), 31);
      checkOutput("w5_valid_r_top",  int'(val5_r), 1);
      for (int k = 0; k < 8; k++) begin
         in5 = $urandom() & $urandom();
         #1;
         checkOutput("w5_result_rand", int'(res5), modelIdx({32'd0, in5}, 32, 1'b1));
         checkOutput("w5_valid_rand",  int'(val5), modelValid({32'd0, in5}, 32));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
